// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one 256-bit line request from the cache arbiter
// into a 4-beat, 64-bit burst on the physical-memory port.
// On a read it gathers the beats into one line; on a write it sends the
// line out one beat at a time. Each line request ends with a one-cycle
// line_resp pulse.
// Optional build macro: CACHELINE_ADAPTOR_PROTO_CHECK_EN adds a sticky
// proto_err output that flags protocol violations.
//
// state | meaning
// IDLE  | waiting; samples line_read / line_write
// RD    | burst read in progress; one beat stored per burst_resp
// WR    | burst write in progress; one beat sent per burst_resp
// DONE  | line_resp pulse; beat count cleared
module cacheline_adaptor #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      line_read,
  input  logic                      line_write,
  input  logic [31:0]               line_addr,
  input  logic [BEATS*BEAT_W-1:0]   line_wdata,
  output logic [BEATS*BEAT_W-1:0]   line_rdata,
  output logic                      line_resp,
  output logic                      burst_read,
  output logic                      burst_write,
  output logic [31:0]               burst_addr,
  output logic [BEAT_W-1:0]         burst_wdata,
  input  logic [BEAT_W-1:0]         burst_rdata,
  input  logic                      burst_resp
`ifdef CACHELINE_ADAPTOR_PROTO_CHECK_EN
  ,
  output logic                      proto_err
`endif
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(BEATS * BEAT_W / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   count;
  logic [31:0]        addr_q;
  logic [BEAT_W-1:0]  wbuf [BEATS];
  logic [BEAT_W-1:0]  rbuf [BEATS];

  // The byte offset inside a line has no meaning on the burst port.
  logic unused_addr_bits;
  assign unused_addr_bits = ^line_addr[OFF_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode; a read wins when both requests are high
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (line_read)       state_n = RD;
        else if (line_write) state_n = WR;
      end
      RD:      if (burst_resp && count == LAST) state_n = DONE;
      WR:      if (burst_resp && count == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Address/data latching, beat counting and read-line capture
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      addr_q <= '0;
      for (int i = 0; i < BEATS; i++) begin
        wbuf[i] <= '0;
        rbuf[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (line_read || line_write)
            addr_q <= {line_addr[31:OFF_W], {OFF_W{1'b0}}};
          if (!line_read && line_write)
            for (int i = 0; i < BEATS; i++)
              wbuf[i] <= line_wdata[i*BEAT_W +: BEAT_W];
        end
        RD: begin
          if (burst_resp) begin
            rbuf[count] <= burst_rdata;
            count       <= count + 1'b1;
          end
        end
        WR:      if (burst_resp) count <= count + 1'b1;
        DONE:    count <= '0;
        default: count <= '0;
      endcase
    end
  end

  // Moore outputs decoded from the registered state only
  assign burst_read  = (state == RD);
  assign burst_write = (state == WR);
  assign line_resp   = (state == DONE);
  assign burst_addr  = addr_q;
  assign burst_wdata = (state == WR) ? wbuf[count] : '0;

  // Word 0 of the line sits in the low bits
  always_comb begin
    line_rdata = '0;
    for (int i = 0; i < BEATS; i++)
      line_rdata[i*BEAT_W +: BEAT_W] = rbuf[i];
  end

`ifdef CACHELINE_ADAPTOR_PROTO_CHECK_EN
  // Sticky flag for double requests, stray beats and requests dropped mid-burst
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if ((state == IDLE && line_read && line_write) ||
                 ((state == IDLE || state == DONE) && burst_resp) ||
                 (state == RD && !line_read) ||
                 (state == WR && !line_write)) begin
      proto_err <= 1'b1;
    end
  end
`else
  // Without the checker these conditions are handled silently by the FSM.
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: expected read lines and write beats
// are queued when each request is issued and compared as the DUT emits them.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_addr;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;
`ifdef CACHELINE_ADAPTOR_PROTO_CHECK_EN
  logic         proto_err;
`endif

  cacheline_adaptor dut (
    .clk         (clk),
    .rst         (rst),
    .line_read   (line_read),
    .line_write  (line_write),
    .line_addr   (line_addr),
    .line_wdata  (line_wdata),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .burst_read  (burst_read),
    .burst_write (burst_write),
    .burst_addr  (burst_addr),
    .burst_wdata (burst_wdata),
    .burst_rdata (burst_rdata),
    .burst_resp  (burst_resp)
`ifdef CACHELINE_ADAPTOR_PROTO_CHECK_EN
    ,
    .proto_err   (proto_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [255:0] exp_line_q [$];
  logic [63:0]  exp_beat_q [$];
  logic [255:0] model_rdata;

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive burst inputs, check write beats before the edge,
  // check the returned line after it.
  task automatic step(input logic resp, input logic [63:0] rd);
    burst_resp  = resp;
    burst_rdata = rd;
    if (burst_write && resp) begin
      chk("wbeat_avail", 256'(exp_beat_q.size() != 0), 256'd1);
      if (exp_beat_q.size() != 0)
        chk("burst_wdata", 256'(burst_wdata), 256'(exp_beat_q.pop_front()));
    end
    @(posedge clk);
    #1;
    if (line_resp) begin
      chk("line_avail", 256'(exp_line_q.size() != 0), 256'd1);
      if (exp_line_q.size() != 0)
        chk("line_rdata", line_rdata, exp_line_q.pop_front());
    end
  endtask

  logic [63:0] beats [4];
  logic        pat   [7];

  initial begin
    rst = 1'b1; line_read = 1'b0; line_write = 1'b0; line_addr = '0;
    line_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
    model_rdata = '0;
    step(1'b0, 64'h0);
    step(1'b0, 64'h0);
    chk("rst_line_resp",   256'(line_resp), 256'd0);
    chk("rst_burst_read",  256'(burst_read), 256'd0);
    chk("rst_burst_write", 256'(burst_write), 256'd0);
    chk("rst_burst_addr",  256'(burst_addr), 256'd0);
    chk("rst_burst_wdata", 256'(burst_wdata), 256'd0);
    chk("rst_line_rdata",  line_rdata, 256'd0);
`ifdef CACHELINE_ADAPTOR_PROTO_CHECK_EN
    chk("rst_proto_err", 256'(proto_err), 256'd0);
`endif
    rst = 1'b0;

    // Read 0x1234, beats in cycles T+2..T+5, response at T+6
    model_rdata = {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)};
    exp_line_q.push_back(model_rdata);
    line_read = 1'b1; line_addr = 32'h0000_1234;
    step(1'b0, 64'h0);
    chk("rd1_burst_read", 256'(burst_read), 256'd1);
    chk("rd1_burst_addr", 256'(burst_addr), 256'h0000_1220);
    step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, rep(8'h11));
    step(1'b1, rep(8'h22));
    step(1'b1, rep(8'h33));
    chk("rd1_no_early_resp", 256'(line_resp), 256'd0);
    step(1'b1, rep(8'h44));
    chk("rd1_resp_t6", 256'(line_resp), 256'd1);
    chk("rd1_addr_done", 256'(burst_addr), 256'h0000_1220);
    step(1'b0, 64'h0);
    line_read = 1'b0;
    chk("rd1_resp_one_cycle", 256'(line_resp), 256'd0);

    // Write 0x40 with words A0..A3; line_rdata must not change
    line_write = 1'b1; line_addr = 32'h0000_0040;
    line_wdata = {rep(8'hA3), rep(8'hA2), rep(8'hA1), rep(8'hA0)};
    for (int i = 0; i < 4; i++) exp_beat_q.push_back(rep(8'hA0 + 8'(i)));
    exp_line_q.push_back(model_rdata);
    step(1'b0, 64'h0);
    chk("wr1_burst_write", 256'(burst_write), 256'd1);
    chk("wr1_burst_read",  256'(burst_read), 256'd0);
    chk("wr1_burst_addr",  256'(burst_addr), 256'h0000_0040);
    line_wdata = '1;
    for (int i = 0; i < 4; i++) step(1'b1, 64'h0);
    chk("wr1_resp", 256'(line_resp), 256'd1);
    chk("wr1_all_beats", 256'(exp_beat_q.size()), 256'd0);
    step(1'b1, 64'hBAD0_BAD0_BAD0_BAD0);
    line_write = 1'b0;

    // Stray beats while idle are ignored
    step(1'b1, 64'hBAD1_BAD1_BAD1_BAD1);
    step(1'b1, 64'hBAD2_BAD2_BAD2_BAD2);
    chk("stray_no_read", 256'(burst_read), 256'd0);
    chk("stray_no_resp", 256'(line_resp), 256'd0);
    chk("stray_rdata",   line_rdata, model_rdata);
`ifdef CACHELINE_ADAPTOR_PROTO_CHECK_EN
    chk("stray_proto_err", 256'(proto_err), 256'd1);
`endif

    // Read with beat gaps 1,0,0,1,1,0,1
    beats[0] = 64'h0123_4567_89AB_CDEF;
    beats[1] = 64'hFEDC_BA98_7654_3210;
    beats[2] = 64'h0F0F_1E1E_2D2D_3C3C;
    beats[3] = 64'h5A5A_6B6B_7C7C_8D8D;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    pat[4] = 1'b1; pat[5] = 1'b0; pat[6] = 1'b1;
    model_rdata = {beats[3], beats[2], beats[1], beats[0]};
    exp_line_q.push_back(model_rdata);
    line_read = 1'b1; line_addr = 32'h0000_0100;
    step(1'b0, 64'h0);
    begin
      int k;
      k = 0;
      for (int i = 0; i < 7; i++) begin
        chk("gap_burst_read", 256'(burst_read), 256'd1);
        if (pat[i]) begin
          step(1'b1, beats[k]);
          k++;
        end else begin
          step(1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
        end
      end
    end
    chk("gap_resp", 256'(line_resp), 256'd1);
    step(1'b0, 64'h0);
    line_read = 1'b0;

    // Write then read back to back, read raised right after the write response
    line_write = 1'b1; line_addr = 32'h0000_0080;
    line_wdata = {rep(8'h53), rep(8'h52), rep(8'h51), rep(8'h50)};
    for (int i = 0; i < 4; i++) exp_beat_q.push_back(rep(8'h50 + 8'(i)));
    exp_line_q.push_back(model_rdata);
    step(1'b0, 64'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 64'h0);
    chk("b2b_wr_resp", 256'(line_resp), 256'd1);
    step(1'b0, 64'h0);
    line_write = 1'b0; line_read = 1'b1; line_addr = 32'h0000_01A0;
    model_rdata = {rep(8'hC4), rep(8'hC3), rep(8'hC2), rep(8'hC1)};
    exp_line_q.push_back(model_rdata);
    step(1'b0, 64'h0);
    chk("b2b_rd_start", 256'(burst_read), 256'd1);
    chk("b2b_rd_addr",  256'(burst_addr), 256'h0000_01A0);
    for (int i = 0; i < 4; i++) step(1'b1, rep(8'hC1 + 8'(i)));
    chk("b2b_rd_resp", 256'(line_resp), 256'd1);
    step(1'b0, 64'h0);
    line_read = 1'b0;

    // Reset after two read beats
    line_read = 1'b1; line_addr = 32'h0000_2000;
    step(1'b0, 64'h0);
    step(1'b1, rep(8'hE1));
    step(1'b1, rep(8'hE2));
    rst = 1'b1; line_read = 1'b0;
    step(1'b0, 64'h0);
    model_rdata = '0;
    chk("rstmid_burst_read",  256'(burst_read), 256'd0);
    chk("rstmid_burst_write", 256'(burst_write), 256'd0);
    chk("rstmid_line_resp",   256'(line_resp), 256'd0);
    chk("rstmid_burst_addr",  256'(burst_addr), 256'd0);
    chk("rstmid_line_rdata",  line_rdata, model_rdata);
`ifdef CACHELINE_ADAPTOR_PROTO_CHECK_EN
    chk("rstmid_proto_err", 256'(proto_err), 256'd0);
`endif
    rst = 1'b0;
    step(1'b0, 64'h0);
    chk("rstmid_idle", 256'(burst_read), 256'd0);

    // Fresh read after the abort
    model_rdata = {rep(8'h74), rep(8'h73), rep(8'h72), rep(8'h71)};
    exp_line_q.push_back(model_rdata);
    line_read = 1'b1; line_addr = 32'h0000_2020;
    step(1'b0, 64'h0);
    chk("fresh_addr", 256'(burst_addr), 256'h0000_2020);
    for (int i = 0; i < 4; i++) step(1'b1, rep(8'h71 + 8'(i)));
    chk("fresh_resp", 256'(line_resp), 256'd1);
    step(1'b0, 64'h0);
    line_read = 1'b0;

    // Both requests high: the read wins
    model_rdata = {rep(8'h94), rep(8'h93), rep(8'h92), rep(8'h91)};
    exp_line_q.push_back(model_rdata);
    line_read = 1'b1; line_write = 1'b1; line_addr = 32'h0000_3000;
    line_wdata = {4{rep(8'h66)}};
    step(1'b0, 64'h0);
    chk("both_burst_read",  256'(burst_read), 256'd1);
    chk("both_burst_write", 256'(burst_write), 256'd0);
    for (int i = 0; i < 4; i++) step(1'b1, rep(8'h91 + 8'(i)));
    chk("both_resp", 256'(line_resp), 256'd1);
`ifdef CACHELINE_ADAPTOR_PROTO_CHECK_EN
    chk("both_proto_err", 256'(proto_err), 256'd1);
`endif
    step(1'b0, 64'h0);
    line_read = 1'b0; line_write = 1'b0;
    step(1'b0, 64'h0);
    step(1'b0, 64'h0);
    chk("both_rdata_hold", line_rdata, model_rdata);
`ifdef CACHELINE_ADAPTOR_PROTO_CHECK_EN
    chk("proto_err_sticky", 256'(proto_err), 256'd1);
    rst = 1'b1;
    step(1'b0, 64'h0);
    rst = 1'b0;
    chk("proto_err_cleared", 256'(proto_err), 256'd0);
`endif

    chk("lines_all_returned", 256'(exp_line_q.size()), 256'd0);
    chk("beats_all_sent", 256'(exp_beat_q.size()), 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
